// File: rtl/vnlp_list_loader.sv
// ---------------------------------------------------------------------------
// vnlp_list_loader
//
// Upstream feeder for the VNLP norm engine. Accepts (x,y) entries over a
// valid/ready stream and builds a doubly linked list in the shared M2 node
// memory. Each node occupies four words starting at its base p:
//    [p]   next pointer (NIL on the final node)
//    [p+1] prev pointer (NIL on the head node)
//    [p+2] x (float24: sign/mant15/exp8)
//    [p+3] y (float24)
// When the list is complete the head pointer and node count are presented
// and vnlp_start pulses for one cycle.
//
// Ports
//    clk         system clock, rising edge
//    rst         synchronous active-high reset
//    load_start  begin a new list session (honoured in IDLE only)
//    in_valid    entry valid
//    in_ready    loader can accept an entry (high in ACCEPT only)
//    in_x, in_y  entry components
//    in_last     entry is the final node of the list
//    mem_we      node memory write strobe, one word per cycle
//    mem_addr    node memory write address
//    mem_wdata   node memory write data (pointers zero-extended)
//    head_ptr    list head; BASE_ADDR after a completed load, NIL otherwise
//    node_count  nodes written in the current/last session
//    overflow    sticky: list was truncated at MAX_NODES
//    vnlp_start  one-cycle pulse when the list is complete
//
// State table
//    state   | meaning
//    IDLE    | waiting for load_start; stream not ready
//    ACCEPT  | in_ready high; waiting for one entry
//    W_NEXT  | writing next pointer of current node
//    W_PREV  | writing prev pointer of current node
//    W_X     | writing x of current node
//    W_Y     | writing y; node committed, pointers advance
//    FINISH  | head_ptr valid, vnlp_start high for this cycle
//
// STRIDE must be >= 4 and BASE_ADDR + MAX_NODES*STRIDE must stay below NIL,
// so that pointer arithmetic never wraps and never produces NIL.
// ---------------------------------------------------------------------------
module vnlp_list_loader #(
   parameter int unsigned          DATA_W    = 24,
   parameter int unsigned          ADDR_W    = 8,
   parameter int unsigned          BASE_ADDR = 0,
   parameter int unsigned          STRIDE    = 5,
   parameter int unsigned          MAX_NODES = 48,
   parameter logic [ADDR_W-1:0]    NIL       = 8'hFF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_start,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_x,
   input  logic [DATA_W-1:0]  in_y,
   input  logic               in_last,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   output logic [ADDR_W-1:0]  head_ptr,
   output logic [6:0]         node_count,
   output logic               overflow,
   output logic               vnlp_start
);

   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(STRIDE);
   localparam logic [6:0]        LAST_IDX = 7'(MAX_NODES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACCEPT = 3'd1,
      W_NEXT = 3'd2,
      W_PREV = 3'd3,
      W_X    = 3'd4,
      W_Y    = 3'd5,
      FINISH = 3'd6
   } state_t;

   state_t              state;
   state_t              state_nx;

   logic [ADDR_W-1:0]   cur;
   logic [ADDR_W-1:0]   prev;
   logic [DATA_W-1:0]   x_q;
   logic [DATA_W-1:0]   y_q;
   logic                eff_last;

   logic                xfer;
   logic                cap_hit;
   logic                eff_last_now;
   logic [ADDR_W-1:0]   cur_step;

   logic                we_nx;
   logic [ADDR_W-1:0]   addr_nx;
   logic [DATA_W-1:0]   wdata_nx;

   // in_ready is a registered copy of (state == ACCEPT), so the transfer
   // condition can be taken straight from the state.
   assign xfer         = (state == ACCEPT) && in_valid;
   assign cap_hit      = (node_count == LAST_IDX);
   assign eff_last_now = in_last | cap_hit;
   assign cur_step     = cur + STEP;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // -------------------------------------------------------------------------
   // Next state and next values of the registered memory port.
   // Each write word is prepared in the cycle before its write state so that
   // mem_we/mem_addr/mem_wdata come straight from flops.
   // -------------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      we_nx    = 1'b0;
      addr_nx  = mem_addr;
      wdata_nx = mem_wdata;

      case (state)
         IDLE: begin
            if (load_start) begin
               state_nx = ACCEPT;
            end
         end

         ACCEPT: begin
            if (in_valid) begin
               state_nx = W_NEXT;
               we_nx    = 1'b1;
               addr_nx  = cur;
               // eff_last is being captured on this same edge, so use the
               // live value for the next-pointer word.
               wdata_nx = eff_last_now ? DATA_W'(NIL) : DATA_W'(cur_step);
            end
         end

         W_NEXT: begin
            state_nx = W_PREV;
            we_nx    = 1'b1;
            addr_nx  = cur + ADDR_W'(1);
            wdata_nx = DATA_W'(prev);
         end

         W_PREV: begin
            state_nx = W_X;
            we_nx    = 1'b1;
            addr_nx  = cur + ADDR_W'(2);
            wdata_nx = x_q;
         end

         W_X: begin
            state_nx = W_Y;
            we_nx    = 1'b1;
            addr_nx  = cur + ADDR_W'(3);
            wdata_nx = y_q;
         end

         W_Y: begin
            state_nx = eff_last ? FINISH : ACCEPT;
         end

         FINISH: begin
            state_nx = IDLE;
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath and registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready   <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         head_ptr   <= NIL;
         node_count <= '0;
         overflow   <= 1'b0;
         vnlp_start <= 1'b0;
         cur        <= BASE;
         prev       <= NIL;
         x_q        <= '0;
         y_q        <= '0;
         eff_last   <= 1'b0;
      end else begin
         in_ready   <= (state_nx == ACCEPT);
         vnlp_start <= (state_nx == FINISH);
         mem_we     <= we_nx;
         mem_addr   <= addr_nx;
         mem_wdata  <= wdata_nx;

         case (state)
            IDLE: begin
               if (load_start) begin
                  cur        <= BASE;
                  prev       <= NIL;
                  node_count <= '0;
                  overflow   <= 1'b0;
                  head_ptr   <= NIL;
               end
            end

            ACCEPT: begin
               if (xfer) begin
                  x_q      <= in_x;
                  y_q      <= in_y;
                  eff_last <= eff_last_now;
                  // Truncation only when capacity, not the producer, ended
                  // the list.
                  if (cap_hit && !in_last) begin
                     overflow <= 1'b1;
                  end
               end
            end

            W_Y: begin
               node_count <= node_count + 7'd1;
               prev       <= cur;
               cur        <= cur_step;
               if (eff_last) begin
                  head_ptr <= BASE;
               end
            end

            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vnlp_list_loader.sv
module tb_vnlp_list_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_x;
   logic [23:0] in_y;
   logic        in_last;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [23:0] mem_wdata;
   logic [7:0]  head_ptr;
   logic [6:0]  node_count;
   logic        overflow;
   logic        vnlp_start;

   int total = 0;
   int bad   = 0;

   logic [23:0] tmem [0:255];
   logic        clr = 1'b0;
   int          wcount = 0;
   int          scount = 0;

   always #5 clk = ~clk;

   vnlp_list_loader #(
      .MAX_NODES (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_last    (in_last),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .head_ptr   (head_ptr),
      .node_count (node_count),
      .overflow   (overflow),
      .vnlp_start (vnlp_start)
   );

   // Node memory image, write and start-pulse counters
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 256; i++) tmem[i] <= 24'hAAAAAA;
      end else if (mem_we) begin
         tmem[mem_addr] <= mem_wdata;
      end
      if (mem_we)     wcount <= wcount + 1;
      if (vnlp_start) scount <= scount + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_mem();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic do_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   // Present one entry, wait for in_ready, return in the cycle after the
   // transfer with in_valid dropped.
   task automatic send(input logic [23:0] x, input logic [23:0] y, input logic l);
      int n;
      in_x = x; in_y = y; in_last = l; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      chk("send_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   // Count cycles until vnlp_start is seen (bounded).
   task automatic wait_start(output int k);
      k = 0;
      while (!vnlp_start && k < 40) begin
         tick();
         k++;
      end
      chk("start_seen", {31'd0, vnlp_start}, 32'd1);
   endtask

   initial begin
      int k;
      int w0;
      int s0;

      rst = 1'b1; load_start = 1'b1; in_valid = 1'b0;
      in_x = '0; in_y = '0; in_last = 1'b0;
      tick(); tick();
      // reset state, rst wins over load_start
      chk("rst_in_ready",  {31'd0, in_ready},   32'd0);
      chk("rst_mem_we",    {31'd0, mem_we},     32'd0);
      chk("rst_mem_addr",  {24'd0, mem_addr},   32'd0);
      chk("rst_mem_wdata", {8'd0, mem_wdata},   32'd0);
      chk("rst_head",      {24'd0, head_ptr},   32'hFF);
      chk("rst_count",     {25'd0, node_count}, 32'd0);
      chk("rst_ovf",       {31'd0, overflow},   32'd0);
      chk("rst_start",     {31'd0, vnlp_start}, 32'd0);
      rst = 1'b0; load_start = 1'b0;
      tick();
      chk("idle_after_rst", {31'd0, in_ready}, 32'd0);
      clear_mem();

      // ---- T1 single node ----
      w0 = wcount;
      do_load();
      chk("t1_ready", {31'd0, in_ready}, 32'd1);
      chk("t1_head_nil", {24'd0, head_ptr}, 32'hFF);
      send(24'h84C006, 24'h5F0005, 1'b1);
      chk("t1_ready_drop", {31'd0, in_ready}, 32'd0);
      chk("t1_wnext_we",   {31'd0, mem_we},   32'd1);
      chk("t1_wnext_addr", {24'd0, mem_addr}, 32'd0);
      chk("t1_wnext_data", {8'd0, mem_wdata}, 32'h0000FF);
      wait_start(k);
      chk("t1_latency", k, 32'd4);
      chk("t1_head",  {24'd0, head_ptr},   32'd0);
      chk("t1_count", {25'd0, node_count}, 32'd1);
      tick();
      chk("t1_start_once", {31'd0, vnlp_start}, 32'd0);
      chk("t1_m0", {8'd0, tmem[0]}, 32'h0000FF);
      chk("t1_m1", {8'd0, tmem[1]}, 32'h0000FF);
      chk("t1_m2", {8'd0, tmem[2]}, 32'h84C006);
      chk("t1_m3", {8'd0, tmem[3]}, 32'h5F0005);
      chk("t1_writes", wcount - w0, 32'd4);
      chk("t1_ovf", {31'd0, overflow}, 32'd0);

      // ---- T2 three nodes ----
      clear_mem();
      w0 = wcount;
      do_load();
      send(24'h111111, 24'h222222, 1'b0);
      send(24'h333333, 24'h444444, 1'b0);
      send(24'h555555, 24'h666666, 1'b1);
      wait_start(k);
      tick();
      chk("t2_n0",  {8'd0, tmem[0]},  32'h000005);
      chk("t2_n5",  {8'd0, tmem[5]},  32'h00000A);
      chk("t2_n10", {8'd0, tmem[10]}, 32'h0000FF);
      chk("t2_p1",  {8'd0, tmem[1]},  32'h0000FF);
      chk("t2_p6",  {8'd0, tmem[6]},  32'h000000);
      chk("t2_p11", {8'd0, tmem[11]}, 32'h000005);
      chk("t2_x7",  {8'd0, tmem[7]},  32'h333333);
      chk("t2_y13", {8'd0, tmem[13]}, 32'h666666);
      chk("t2_count", {25'd0, node_count}, 32'd3);
      chk("t2_writes", wcount - w0, 32'd12);

      // ---- T3 backpressure: in_valid held high ----
      clear_mem();
      do_load();
      in_valid = 1'b1;
      in_x = 24'hA00001; in_y = 24'hB00001; in_last = 1'b0;
      chk("t3_ready0", {31'd0, in_ready}, 32'd1);
      tick();
      in_x = 24'hA00002; in_y = 24'hB00002;
      k = 0;
      while (!in_ready && k < 40) begin tick(); k++; end
      chk("t3_gap1", k, 32'd4);
      tick();
      in_x = 24'hA00003; in_y = 24'hB00003; in_last = 1'b1;
      k = 0;
      while (!in_ready && k < 40) begin tick(); k++; end
      chk("t3_gap2", k, 32'd4);
      tick();
      in_valid = 1'b0;
      wait_start(k);
      tick();
      chk("t3_x2",  {8'd0, tmem[2]},  32'hA00001);
      chk("t3_x7",  {8'd0, tmem[7]},  32'hA00002);
      chk("t3_x12", {8'd0, tmem[12]}, 32'hA00003);
      chk("t3_y13", {8'd0, tmem[13]}, 32'hB00003);
      chk("t3_n15", {8'd0, tmem[15]}, 32'hAAAAAA);
      chk("t3_count", {25'd0, node_count}, 32'd3);

      // ---- T4 overflow at MAX_NODES=4 ----
      clear_mem();
      w0 = wcount;
      s0 = scount;
      do_load();
      send(24'h000101, 24'h000201, 1'b0);
      send(24'h000102, 24'h000202, 1'b0);
      send(24'h000103, 24'h000203, 1'b0);
      chk("t4_ovf_early", {31'd0, overflow}, 32'd0);
      send(24'h000104, 24'h000204, 1'b0);
      chk("t4_ovf_set", {31'd0, overflow}, 32'd1);
      in_x = 24'h000105; in_y = 24'h000205; in_valid = 1'b1;
      k = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (in_ready) k++;
      end
      in_valid = 1'b0;
      chk("t4_no_ready", k, 32'd0);
      chk("t4_starts", scount - s0, 32'd1);
      chk("t4_writes", wcount - w0, 32'd16);
      chk("t4_n10", {8'd0, tmem[10]}, 32'h00000F);
      chk("t4_n15", {8'd0, tmem[15]}, 32'h0000FF);
      chk("t4_p16", {8'd0, tmem[16]}, 32'h00000A);
      chk("t4_m20", {8'd0, tmem[20]}, 32'hAAAAAA);
      chk("t4_count", {25'd0, node_count}, 32'd4);
      chk("t4_ovf", {31'd0, overflow}, 32'd1);
      chk("t4_head", {24'd0, head_ptr}, 32'd0);

      // ---- T5 rst during W_X of node 2 ----
      clear_mem();
      w0 = wcount;
      s0 = scount;
      do_load();
      send(24'h0C0001, 24'h0D0001, 1'b0);
      send(24'h0C0002, 24'h0D0002, 1'b0);
      tick();                       // W_PREV
      tick();                       // W_X
      chk("t5_in_wx", {24'd0, mem_addr}, 32'd7);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_ready",  {31'd0, in_ready},   32'd0);
      chk("t5_we",     {31'd0, mem_we},     32'd0);
      chk("t5_addr",   {24'd0, mem_addr},   32'd0);
      chk("t5_wdata",  {8'd0, mem_wdata},   32'd0);
      chk("t5_head",   {24'd0, head_ptr},   32'hFF);
      chk("t5_count",  {25'd0, node_count}, 32'd0);
      chk("t5_ovf",    {31'd0, overflow},   32'd0);
      for (int i = 0; i < 10; i++) tick();
      chk("t5_writes", wcount - w0, 32'd7);
      chk("t5_nostart", scount - s0, 32'd0);
      chk("t5_m8", {8'd0, tmem[8]}, 32'hAAAAAA);
      do_load();
      send(24'h0E0001, 24'h0F0001, 1'b1);
      wait_start(k);
      tick();
      chk("t5_re_n0", {8'd0, tmem[0]}, 32'h0000FF);
      chk("t5_re_x2", {8'd0, tmem[2]}, 32'h0E0001);
      chk("t5_re_count", {25'd0, node_count}, 32'd1);

      // ---- T6 stray controls ----
      w0 = wcount;
      in_x = 24'h777777; in_y = 24'h888888; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      in_valid = 1'b0;
      chk("t6_idle_ready", {31'd0, in_ready}, 32'd0);
      chk("t6_idle_writes", wcount - w0, 32'd0);
      chk("t6_idle_m2", {8'd0, tmem[2]}, 32'h0E0001);
      chk("t6_idle_count", {25'd0, node_count}, 32'd1);
      w0 = wcount;
      s0 = scount;
      do_load();
      send(24'h123456, 24'h654321, 1'b0);
      tick();                       // W_PREV
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      send(24'h0ABCDE, 24'h0EDCBA, 1'b1);
      wait_start(k);
      tick();
      chk("t6_n0", {8'd0, tmem[0]}, 32'h000005);
      chk("t6_p1", {8'd0, tmem[1]}, 32'h0000FF);
      chk("t6_n5", {8'd0, tmem[5]}, 32'h0000FF);
      chk("t6_p6", {8'd0, tmem[6]}, 32'h000000);
      chk("t6_x7", {8'd0, tmem[7]}, 32'h0ABCDE);
      chk("t6_count", {25'd0, node_count}, 32'd2);
      chk("t6_writes", wcount - w0, 32'd8);
      chk("t6_starts", scount - s0, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
